// File: rtl/oscilo_pkg.sv
// Shared types and helpers for the oscilloscope capture readout path.
package oscilo_pkg;

    typedef enum logic [2:0] {
        IDLE,
        HDR,
        FETCH,
        WAIT,
        SEND,
        CSUM,
        DONE
    } readout_state_t;

    // Byte positions within the 3-byte frame header
    localparam logic [1:0] HDR_ID     = 2'd0;
    localparam logic [1:0] HDR_LEN_HI = 2'd1;
    localparam logic [1:0] HDR_LEN_LO = 2'd2;

    // Ring-buffer subtraction; mask = depth-1 keeps the result inside the ring
    function automatic logic [15:0] ring_addr_sub(input logic [15:0] a, input logic [15:0] b,
                                                  input logic [15:0] mask);
        return (a - b) & mask;
    endfunction

endpackage

// File: rtl/capture_readout.sv
// Streams a completed capture out of the circular sample RAM as a framed byte stream.
// Optional trailing XOR checksum byte when READOUT_CHECKSUM_EN is defined.
module capture_readout
    import oscilo_pkg::*;
#(
    parameter logic [7:0] MODULE_ID    = 8'h11,
    parameter int         SAMPLE_DEPTH = 1024,
    localparam int        ADDR_W       = $clog2(SAMPLE_DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] trig_addr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd_en,
    input  logic [7:0]        mem_rdata,
    output logic [7:0]        tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic              busy,
    output logic              done
);

    // 65536 truncates to 16'h0000 in the length field
    localparam logic [15:0]     LEN16    = 16'(SAMPLE_DEPTH);
    localparam logic [15:0]     HALF     = 16'(SAMPLE_DEPTH / 2);
    localparam logic [15:0]     AMASK    = 16'(SAMPLE_DEPTH - 1);
    localparam logic [ADDR_W:0] IDX_LAST = (ADDR_W + 1)'(SAMPLE_DEPTH - 1);

    readout_state_t    state, state_nxt;
    logic [1:0]        hdr_idx;
    logic [ADDR_W:0]   idx;
    logic [ADDR_W-1:0] base;
    logic [7:0]        hold;
    logic              hs, last, hdr_last;

    // tx_valid depends on state only, so tx_ready never reaches it combinationally
`ifdef READOUT_CHECKSUM_EN
    assign tx_valid = (state == HDR) || (state == SEND) || (state == CSUM);
`else
    assign tx_valid = (state == HDR) || (state == SEND);
`endif
    assign hs       = tx_valid && tx_ready;
    assign last     = (idx == IDX_LAST);
    assign hdr_last = (hdr_idx == HDR_LEN_LO);
    assign busy     = (state != IDLE);
    assign done     = (state == DONE);
    assign mem_rd_en = (state == FETCH);

`ifdef READOUT_CHECKSUM_EN
    logic [7:0] csum;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                       csum <= '0;
        else if (state == IDLE && start)  csum <= '0;
        else if (hs && state != CSUM)     csum <= csum ^ tx_data;
    end
`endif

    always_comb begin
        tx_data = '0;
        case (state)
            HDR: begin
                case (hdr_idx)
                    HDR_ID:     tx_data = MODULE_ID;
                    HDR_LEN_HI: tx_data = LEN16[15:8];
                    default:    tx_data = LEN16[7:0];
                endcase
            end
            SEND:    tx_data = hold;
`ifdef READOUT_CHECKSUM_EN
            CSUM:    tx_data = csum;
`endif
            default: tx_data = '0;
        endcase
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (start) state_nxt = HDR;
            HDR:   if (tx_ready && hdr_last) state_nxt = FETCH;
            FETCH: state_nxt = WAIT;
            WAIT:  state_nxt = SEND;
            SEND: begin
                if (tx_ready) begin
                    if (last) begin
`ifdef READOUT_CHECKSUM_EN
                        state_nxt = CSUM;
`else
                        state_nxt = DONE;
`endif
                    end else begin
                        state_nxt = FETCH;
                    end
                end
            end
`ifdef READOUT_CHECKSUM_EN
            CSUM:  if (tx_ready) state_nxt = DONE;
`endif
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            hdr_idx  <= '0;
            idx      <= '0;
            base     <= '0;
            hold     <= '0;
            mem_addr <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (start) begin
                        base    <= ADDR_W'(ring_addr_sub(16'(trig_addr), HALF, AMASK));
                        hdr_idx <= '0;
                        idx     <= '0;
                    end
                end
                HDR: begin
                    if (tx_ready) begin
                        hdr_idx <= hdr_idx + 2'd1;
                        if (hdr_last) mem_addr <= base;
                    end
                end
                WAIT: hold <= mem_rdata;
                SEND: begin
                    // Address only advances for a following sample; holds after the last one
                    if (tx_ready) begin
                        idx <= idx + (ADDR_W + 1)'(1);
                        if (!last) mem_addr <= base + idx[ADDR_W-1:0] + ADDR_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_capture_readout.sv
// Randomized self-checking bench for capture_readout against a frame-level reference model.
module tb_capture_readout;

    localparam int SD = 16;
    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [AW-1:0] trig_addr = '0;
    logic [AW-1:0] mem_addr;
    logic          mem_rd_en;
    logic [7:0]    mem_rdata;
    logic [7:0]    tx_data;
    logic          tx_valid;
    logic          tx_ready = 1'b0;
    logic          busy;
    logic          done;

    logic [7:0]    mem [SD];
    int            errors = 0;
    int            checks = 0;
    logic [7:0]    got[$];
    logic [7:0]    exp_q[$];
    int            done_cnt;
    int            done_at;

    capture_readout #(.MODULE_ID(8'h11), .SAMPLE_DEPTH(SD)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .trig_addr(trig_addr),
        .mem_addr(mem_addr), .mem_rd_en(mem_rd_en), .mem_rdata(mem_rdata),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (mem_rd_en) mem_rdata <= mem[mem_addr];

    // Reference frame: header, then the ring read oldest-first from half a buffer before trigger
    function automatic void build_exp(input int trig);
        int base;
        logic [7:0] x;
        exp_q.delete();
        exp_q.push_back(8'h11);
        exp_q.push_back(8'((SD >> 8) & 255));
        exp_q.push_back(8'(SD & 255));
        base = ((trig - SD / 2) % SD + SD) % SD;
        for (int i = 0; i < SD; i++) exp_q.push_back(8'hA0 + 8'((base + i) % SD));
`ifdef READOUT_CHECKSUM_EN
        x = 8'h00;
        foreach (exp_q[i]) x = x ^ exp_q[i];
        exp_q.push_back(x);
`else
        x = 8'h00;
`endif
    endfunction

    task automatic start_frame(input int t);
        @(negedge clk);
        trig_addr = AW'(t);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Sink: decides tx_ready each negedge and records bytes that will handshake on the next edge
    task automatic collect(input int pct, input int glitch_at, input int stop_at);
        bit         prev_stall = 1'b0;
        logic [7:0] prev_data = '0;
        bit         glitched = 1'b0;
        int         post = -1;
        got.delete();
        done_cnt = 0;
        done_at = -1;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (done === 1'b1) begin
                done_cnt++;
                if (done_at < 0) done_at = cyc;
            end
            if (prev_stall) begin
                checks++;
                if (tx_valid !== 1'b1 || tx_data !== prev_data) begin
                    errors++;
                    $display("FAIL hold_stable: valid=%b data=%h required valid=1 data=%h",
                             tx_valid, tx_data, prev_data);
                end
            end
            tx_ready = ($urandom_range(99) < pct);
            if (tx_valid === 1'b1 && tx_ready) got.push_back(tx_data);
            prev_stall = (tx_valid === 1'b1) && !tx_ready;
            prev_data = tx_data;
            start = 1'b0;
            if (glitch_at >= 0 && !glitched && got.size() == glitch_at) begin
                start = 1'b1;
                trig_addr = AW'($urandom);
                glitched = 1'b1;
            end
            if (stop_at >= 0 && got.size() == stop_at) return;
            if (done_cnt > 0 && post < 0) post = 4;
            else if (post > 0) post--;
            if (post == 0) begin
                tx_ready = 1'b0;
                start = 1'b0;
                return;
            end
            @(negedge clk);
        end
        checks++;
        errors++;
        $display("FAIL collect_timeout: bytes=%0d done=%0d required frame completion", got.size(), done_cnt);
        tx_ready = 1'b0;
        start = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({tx_valid, busy, done, mem_rd_en} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_ctrl: got %b required 0000", {tx_valid, busy, done, mem_rd_en});
        end
        checks++;
        if (tx_data !== 8'h00) begin
            errors++;
            $display("FAIL reset_tx_data: got %h required 00", tx_data);
        end
        checks++;
        if (mem_addr !== '0) begin
            errors++;
            $display("FAIL reset_mem_addr: got %h required 0", mem_addr);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic;
        build_exp(8);
        start_frame(8);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL basic_busy_rise: got %b required 1", busy);
        end
        collect(100, -1, -1);
        checks++;
        if (got.size() != exp_q.size()) begin
            errors++;
            $display("FAIL basic_len: got %0d required %0d", got.size(), exp_q.size());
        end
        for (int i = 0; i < got.size() && i < exp_q.size(); i++) begin
            checks++;
            if (got[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL basic_byte[%0d]: got %h required %h", i, got[i], exp_q[i]);
            end
        end
        checks++;
        if (done_cnt != 1) begin
            errors++;
            $display("FAIL basic_done_count: got %0d required 1", done_cnt);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL basic_busy_after: got %b required 0", busy);
        end
        checks++;
        if (done_at < 0 || done_at > 3 + 3 * SD + 2) begin
            errors++;
            $display("FAIL basic_rate: done at cycle %0d required <= %0d", done_at, 3 + 3 * SD + 2);
        end
`ifdef READOUT_CHECKSUM_EN
        checks++;
        if (got.size() < 20 || got[19] !== 8'h01) begin
            errors++;
            $display("FAIL basic_checksum: got %h required 01", (got.size() >= 20) ? got[19] : 8'hxx);
        end
`endif
    endtask

    task automatic test_wrap;
        build_exp(3);
        start_frame(3);
        collect(100, -1, -1);
        checks++;
        if (got.size() != exp_q.size()) begin
            errors++;
            $display("FAIL wrap_len: got %0d required %0d", got.size(), exp_q.size());
        end
        for (int i = 0; i < got.size() && i < exp_q.size(); i++) begin
            checks++;
            if (got[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL wrap_byte[%0d]: got %h required %h", i, got[i], exp_q[i]);
            end
        end
        checks++;
        if (done_cnt != 1) begin
            errors++;
            $display("FAIL wrap_done_count: got %0d required 1", done_cnt);
        end
    endtask

    task automatic test_backpressure;
        for (int r = 0; r < 3; r++) begin
            int t;
            t = int'($urandom_range(SD - 1));
            build_exp(t);
            start_frame(t);
            collect(30, -1, -1);
            checks++;
            if (got.size() != exp_q.size()) begin
                errors++;
                $display("FAIL bp_len: trig=%0d got %0d required %0d", t, got.size(), exp_q.size());
            end
            for (int i = 0; i < got.size() && i < exp_q.size(); i++) begin
                checks++;
                if (got[i] !== exp_q[i]) begin
                    errors++;
                    $display("FAIL bp_byte[%0d]: trig=%0d got %h required %h", i, t, got[i], exp_q[i]);
                end
            end
            checks++;
            if (done_cnt != 1 || busy !== 1'b0) begin
                errors++;
                $display("FAIL bp_done: done_count=%0d busy=%b required 1 and 0", done_cnt, busy);
            end
        end
    endtask

    task automatic test_start_ignored;
        build_exp(5);
        start_frame(5);
        collect(100, 7, -1);
        checks++;
        if (got.size() != exp_q.size()) begin
            errors++;
            $display("FAIL restart_len: got %0d required %0d", got.size(), exp_q.size());
        end
        for (int i = 0; i < got.size() && i < exp_q.size(); i++) begin
            checks++;
            if (got[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL restart_byte[%0d]: got %h required %h", i, got[i], exp_q[i]);
            end
        end
        checks++;
        if (done_cnt != 1) begin
            errors++;
            $display("FAIL restart_done_count: got %0d required 1", done_cnt);
        end
    endtask

    task automatic test_reset_midframe;
        start_frame(8);
        collect(100, -1, 3 + 5);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({tx_valid, busy, mem_rd_en} !== 3'b000) begin
            errors++;
            $display("FAIL midreset_async: valid/busy/rd_en=%b required 000", {tx_valid, busy, mem_rd_en});
        end
        tx_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            checks++;
            if (tx_valid !== 1'b0) begin
                errors++;
                $display("FAIL midreset_quiet: cycle %0d valid=%b required 0", c, tx_valid);
            end
        end
        tx_ready = 1'b0;
        rst_n = 1'b1;
        build_exp(8);
        start_frame(8);
        collect(100, -1, -1);
        checks++;
        if (got.size() != exp_q.size()) begin
            errors++;
            $display("FAIL midreset_len: got %0d required %0d", got.size(), exp_q.size());
        end
        for (int i = 0; i < got.size() && i < exp_q.size(); i++) begin
            checks++;
            if (got[i] !== exp_q[i]) begin
                errors++;
                $display("FAIL midreset_byte[%0d]: got %h required %h", i, got[i], exp_q[i]);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < SD; i++) mem[i] = 8'hA0 + 8'(i);
        test_reset;
        test_basic;
        test_wrap;
        test_backpressure;
        test_start_ignored;
        test_reset_midframe;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
